rf_alu_pipe: RTL and testbench

- Parametrised successor to the register-file / dual-mux / ALU datapath.
- Executes micro-ops delivered over a valid/ready stream, replacing the fixed 15-bit control word:
  - generalised register count and width;
  - 8 ALU modes instead of 4.
- Two-stage pipeline with write-back forwarding and output backpressure.
- Sits between the control sequencer (producer of micro-ops) and downstream consumers of results and register observation.

---
 rtl/rf_alu_pkg.sv | 17 +
 rtl/rf_alu_pipe_if.sv | 33 +++
 rtl/alu_n.sv | 40 ++++
 rtl/rf_alu_pipe.sv | 112 +++++++++++
 tb/tb_rf_alu_pipe.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_alu_pkg.sv
// Shared encodings for the register-file / ALU pipeline.
// Op-codes and flag bit positions used by the ALU and the pipeline top.
// No logic, constants only.
package rf_alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int FLG_MAYOR = 2;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_CARRY = 0;
endpackage

// File: rtl/rf_alu_pipe_if.sv
// Micro-op stream, result stream and register observation for rf_alu_pipe.
// Ports: in_* (micro-op, valid/ready), out_* (result, valid/ready), obs_* (observe).
// master = sequencer/consumer side, slave = pipeline side.
interface rf_alu_pipe_if #(
  parameter int P_N    = 16,
  parameter int P_NREG = 16
);
  localparam int P_AW = $clog2(P_NREG);

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [P_AW-1:0] in_ra;
  logic [P_AW-1:0] in_rb;
  logic [P_AW-1:0] in_rd;
  logic            in_we;
  logic            out_valid;
  logic            out_ready;
  logic [P_N-1:0]  out_data;
  logic [2:0]      out_flags;
  logic [P_AW-1:0] obs_sel;
  logic [P_N-1:0]  obs_data;

  modport master (
    output in_valid, in_op, in_ra, in_rb, in_rd, in_we, out_ready, obs_sel,
    input  in_ready, out_valid, out_data, out_flags, obs_data
  );

  modport slave (
    input  in_valid, in_op, in_ra, in_rb, in_rd, in_we, out_ready, obs_sel,
    output in_ready, out_valid, out_data, out_flags, obs_data
  );
endinterface

// File: rtl/alu_n.sv
// Combinational P_N-bit ALU: 8 ops, flags {mayor, zero, carry}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: op, a, b in; result, flags out.
module alu_n
  import rf_alu_pkg::*;
#(
  parameter int P_N = 16
) (
  input  logic [2:0]     op,
  input  logic [P_N-1:0] a,
  input  logic [P_N-1:0] b,
  output logic [P_N-1:0] result,
  output logic [2:0]     flags
);
  logic [P_N:0] sum;
  logic         carry;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  begin result = sum[P_N-1:0]; carry = sum[P_N]; end
      // carry on SUB is borrow-not, i.e. a >= b
      OP_SUB:  begin result = a - b; carry = (a >= b); end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  begin result = {a[P_N-2:0], 1'b0}; carry = a[P_N-1]; end
      OP_SHR:  begin result = {1'b0, a[P_N-1:1]}; carry = a[0]; end
      OP_PASS: result = a;
      default: result = a;
    endcase
    flags            = '0;
    flags[FLG_MAYOR] = (a > b);
    flags[FLG_ZERO]  = (result == '0);
    flags[FLG_CARRY] = carry;
  end
endmodule

// File: rtl/rf_alu_pipe.sv
// Register file + ALU executing micro-ops from a valid/ready stream.
// Latency: accept at E0 -> out_valid after E2; throughput 1 op/cycle.
// Backpressure: out_valid & !out_ready freezes every stage, in_ready drops, no writes.
// Ports: clk, rst (sync, active-high), bus (slave): in_* micro-op, out_* result, obs_* observe.
module rf_alu_pipe
  import rf_alu_pkg::*;
#(
  parameter int P_N    = 16,
  parameter int P_NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  rf_alu_pipe_if.slave  bus
);
  localparam int P_AW = $clog2(P_NREG);

  logic [P_N-1:0]  regs [P_NREG];

  // stage 1 (RD): operands captured at accept, ALU runs on these registers
  logic            s1_vld;
  logic [2:0]      s1_op;
  logic [P_AW-1:0] s1_rd;
  logic            s1_we;
  logic [P_N-1:0]  s1_a;
  logic [P_N-1:0]  s1_b;

  // stage 2 (EX): latched ALU result awaiting output / write-back
  logic            s2_vld;
  logic [P_AW-1:0] s2_rd;
  logic            s2_we;
  logic [P_N-1:0]  s2_res;
  logic [2:0]      s2_flg;

  logic [P_N-1:0]  alu_res;
  logic [2:0]      alu_flg;
  logic [P_N-1:0]  opnd_a;
  logic [P_N-1:0]  opnd_b;
  logic            adv;
  logic            acc;

  // single global enable: the whole pipe moves unless the output is stuck
  assign adv          = !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && adv;
  assign bus.in_ready = adv;

  alu_n #(.P_N(P_N)) u_alu (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_res),
    .flags  (alu_flg)
  );

  // Register write happens when stage 2 leaves, so up to two producers can be
  // ahead of an incoming op. Later assignments win: stage 1 is the youngest.
  always_comb begin
    opnd_a = regs[bus.in_ra];
    opnd_b = regs[bus.in_rb];
    if (s2_vld && s2_we && s2_rd == bus.in_ra) opnd_a = s2_res;
    if (s2_vld && s2_we && s2_rd == bus.in_rb) opnd_b = s2_res;
    if (s1_vld && s1_we && s1_rd == bus.in_ra) opnd_a = alu_res;
    if (s1_vld && s1_we && s1_rd == bus.in_rb) opnd_b = alu_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P_NREG; i++) regs[i] <= '0;
      s1_vld        <= 1'b0;
      s1_op         <= '0;
      s1_rd         <= '0;
      s1_we         <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s2_vld        <= 1'b0;
      s2_rd         <= '0;
      s2_we         <= 1'b0;
      s2_res        <= '0;
      s2_flg        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_flags <= '0;
      bus.obs_data  <= '0;
    end else begin
      if (adv) begin
        s1_vld <= acc;
        if (acc) begin
          s1_op <= bus.in_op;
          s1_rd <= bus.in_rd;
          s1_we <= bus.in_we;
          s1_a  <= opnd_a;
          s1_b  <= opnd_b;
        end
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_rd  <= s1_rd;
          s2_we  <= s1_we;
          s2_res <= alu_res;
          s2_flg <= alu_flg;
        end
        // write-back only on the advancing edge, so a stall never repeats it
        bus.out_valid <= s2_vld;
        if (s2_vld) begin
          bus.out_data  <= s2_res;
          bus.out_flags <= s2_flg;
          if (s2_we) regs[s2_rd] <= s2_res;
        end
      end
      // observation port ignores stalls
      bus.obs_data <= regs[bus.obs_sel];
    end
  end
endmodule

// File: tb/tb_rf_alu_pipe.sv
// Self-checking bench for rf_alu_pipe: vector table, hand sequences, random ops.
// Latency: n/a (testbench).
// Backpressure: bench drives out_ready patterns, including long stalls.
module tb_rf_alu_pipe;
  import rf_alu_pkg::*;

  localparam int N    = 16;
  localparam int NREG = 16;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_alu_pipe_if #(.P_N(N), .P_NREG(NREG)) bus ();

  rf_alu_pipe #(.P_N(N), .P_NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] data;
    logic [2:0]   flags;
  } vec_t;

  vec_t         tbl [10];
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc   = 0;
  logic [N-1:0] mdl [NREG];
  logic [18:0]  exp_q [$];
  int           acc_q [$];
  int           out_q [$];
  logic [N-1:0] seed_val;
  logic [N-1:0] last_data;
  logic [2:0]   last_flags;
  bit           got;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Reference ALU from the op definitions, in plain wide arithmetic.
  function automatic logic [18:0] ref_alu(input logic [2:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned m  = 64'(1) << N;
    longint unsigned r  = 0;
    bit              c  = 1'b0;
    case (op)
      OP_ADD:  begin r = ua + ub;     c = (r >= m);      end
      OP_SUB:  begin r = ua + m - ub; c = (ua >= ub);    end
      OP_AND:  r = ua & ub;
      OP_OR:   r = ua | ub;
      OP_XOR:  r = ua ^ ub;
      OP_SHL:  begin r = ua * 2;      c = (ua >= m / 2); end
      OP_SHR:  begin r = ua / 2;      c = (ua % 2 == 1); end
      default: r = ua;
    endcase
    r = r % m;
    return {ua > ub, r == 0, c, r[N-1:0]};
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_ra     = '0;
    bus.in_rb     = '0;
    bus.in_rd     = '0;
    bus.in_we     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // One cycle: drive at negedge, then judge both handshakes of the coming edge.
  task automatic step(input bit iv, input logic [2:0] op, input int ra, input int rb,
                      input int rd, input bit we, input bit ordy);
    logic [18:0] e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_op     = op;
    bus.in_ra     = AW'(ra);
    bus.in_rb     = AW'(rb);
    bus.in_rd     = AW'(rd);
    bus.in_we     = we;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      got        = 1'b1;
      last_data  = bus.out_data;
      last_flags = bus.out_flags;
      out_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL out_unexpected: actual data %0h, required no result", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e[N-1:0]));
        chk("out_flags", 32'(bus.out_flags), 32'(e[18:16]));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e = ref_alu(op, mdl[ra], mdl[rb]);
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      if (we) mdl[rd] = e[N-1:0];
    end
  endtask

  task automatic drain(input int ncyc);
    repeat (ncyc) step(1'b0, OP_ADD, 0, 0, 0, 1'b0, 1'b1);
  endtask

  // Puts a value into a register through the normal write path by overriding
  // the ALU output while a PASS op sits in stage 1. Pipeline must be idle.
  task automatic seed(input int idx, input logic [N-1:0] val);
    seed_val = val;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = OP_PASS; bus.in_ra = '0; bus.in_rb = '0;
    bus.in_rd = AW'(idx); bus.in_we = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    force dut.alu_res = seed_val;
    @(negedge clk);
    release dut.alu_res;
    @(negedge clk);
    @(negedge clk);
    mdl[idx] = val;
  endtask

  task automatic obs_one(input string nm, input int idx, input logic [N-1:0] req);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.obs_sel  = AW'(idx);
    @(negedge clk);
    #1;
    chk(nm, 32'(bus.obs_data), 32'(req));
  endtask

  task automatic obs_all(input string tag);
    for (int i = 0; i < NREG; i++) obs_one($sformatf("%s_r%0d", tag, i), i, mdl[i]);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
    foreach (mdl[i]) mdl[i] = '0;
    exp_q.delete();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{OP_SUB,  16'd25,    16'd7,     16'h0012, 3'b101};
    tbl[1] = '{OP_ADD,  16'hFFFF,  16'h0001,  16'h0000, 3'b111};
    tbl[2] = '{OP_SHR,  16'h0001,  16'h0000,  16'h0000, 3'b111};
    tbl[3] = '{OP_SHL,  16'h8001,  16'h8001,  16'h0002, 3'b001};
    tbl[4] = '{OP_AND,  16'hF0F0,  16'h0FF0,  16'h00F0, 3'b100};
    tbl[5] = '{OP_OR,   16'h1200,  16'h0034,  16'h1234, 3'b100};
    tbl[6] = '{OP_XOR,  16'h5555,  16'h5555,  16'h0000, 3'b010};
    tbl[7] = '{OP_PASS, 16'h0003,  16'h0009,  16'h0003, 3'b000};
    tbl[8] = '{OP_SUB,  16'd7,     16'd25,    16'hFFEE, 3'b000};
    tbl[9] = '{OP_ADD,  16'h1234,  16'h1111,  16'h2345, 3'b100};

    idle_inputs();
    bus.obs_sel = '0;
    foreach (mdl[i]) mdl[i] = '0;

    // reset / idle
    do_reset(2);
    obs_all("rst_obs");

    // vector table: r3 = op(r1, r2)
    foreach (tbl[i]) begin
      seed(1, tbl[i].a);
      seed(2, tbl[i].b);
      acc_q.delete();
      out_q.delete();
      got = 1'b0;
      step(1'b1, tbl[i].op, 1, 2, 3, 1'b1, 1'b1);
      drain(5);
      chk($sformatf("tbl%0d_seen", i), 32'(got), 32'd1);
      chk($sformatf("tbl%0d_data", i), 32'(last_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_flags", i), 32'(last_flags), 32'(tbl[i].flags));
      if (got && acc_q.size() > 0 && out_q.size() > 0)
        chk($sformatf("tbl%0d_latency", i), 32'(out_q[0] - acc_q[0]), 32'd3);
      obs_one($sformatf("tbl%0d_obs", i), 3, tbl[i].data);
    end

    // forwarding: back-to-back dependent ADDs, no bubble
    seed(1, 16'd5);
    out_q.delete();
    step(1'b1, OP_ADD, 1, 1, 4, 1'b1, 1'b1);
    step(1'b1, OP_ADD, 4, 4, 5, 1'b1, 1'b1);
    drain(5);
    chk("fwd_count", 32'(out_q.size()), 32'd2);
    if (out_q.size() == 2) chk("fwd_no_bubble", 32'(out_q[1] - out_q[0]), 32'd1);
    chk("fwd_last", 32'(last_data), 32'd20);
    obs_one("fwd_obs_r4", 4, 16'd10);
    obs_one("fwd_obs_r5", 5, 16'd20);

    // youngest producer wins when two in-flight ops target the same rd
    step(1'b1, OP_ADD,  1, 1, 8, 1'b1, 1'b1);
    step(1'b1, OP_PASS, 1, 0, 8, 1'b1, 1'b1);
    step(1'b1, OP_ADD,  8, 8, 9, 1'b1, 1'b1);
    drain(5);
    chk("young_last", 32'(last_data), 32'd10);
    obs_one("young_obs_r8", 8, 16'd5);
    obs_one("young_obs_r9", 9, 16'd10);

    // backpressure: three r6 += r7 ops queued behind a 5-cycle stall
    seed(6, 16'd0);
    seed(7, 16'd1);
    out_q.delete();
    repeat (3) step(1'b1, OP_ADD, 6, 7, 6, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, OP_ADD, 6, 7, 6, 1'b1, 1'b0);
      chk($sformatf("bp_in_ready%0d", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_out_valid%0d", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_hold%0d", k), 32'(bus.out_data), 32'd1);
    end
    drain(6);
    chk("bp_count", 32'(out_q.size()), 32'd3);
    if (out_q.size() == 3) chk("bp_back_to_back", 32'(out_q[2] - out_q[0]), 32'd2);
    obs_one("bp_obs_r6", 6, 16'd3);

    // reset with two ops in flight
    seed(1, 16'd5);
    step(1'b1, OP_ADD, 1, 1, 2, 1'b1, 1'b1);
    step(1'b1, OP_ADD, 1, 1, 3, 1'b1, 1'b1);
    do_reset(1);
    obs_all("midrst_obs");

    // random ops against the reference model
    for (int i = 0; i < NREG; i++) seed(i, N'($urandom));
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
           int'($urandom_range(0, NREG - 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    end
    drain(10);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    obs_all("rand_obs");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
